// File: rtl/count_cascade_capture_pkg.sv
// Shared constants, capture FSM encoding and snapshot width helper
// for the counter cascade/capture stage.
package count_cascade_capture_pkg;

  // Width of the lower 4-bit parallel-load counter feeding this stage
  localparam int LOW_W = 4;

  // Capture port state: IDLE has no snapshot pending, HOLD presents one
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } cap_state_t;

  // Full snapshot width: upper counter bits plus the lower counter bits
  function automatic int snap_width(input int width_hi);
    return width_hi + LOW_W;
  endfunction

endpackage

// File: rtl/count_cascade_capture_if.sv
// Capture port carrying the {high,low} snapshot to a readout consumer.
// Valid/ready: data and valid held by the producer until ready is seen.
interface count_cascade_capture_if #(
  parameter int WIDTH_HI = 4
);
  import count_cascade_capture_pkg::*;

  logic [snap_width(WIDTH_HI)-1:0] Cap_data;
  logic                            Cap_valid;
  logic                            Cap_ready;

  modport master (
    output Cap_data,
    output Cap_valid,
    input  Cap_ready
  );

  modport slave (
    input  Cap_data,
    input  Cap_valid,
    output Cap_ready
  );

endinterface

// File: rtl/count_cascade_capture_upper_counter.sv
// Upper counter of the cascade: parallel load, carry increment, sticky overflow.
// High_count follows a sampled carry one edge later; no backpressure.
module cascade_upper_counter #(
  parameter int WIDTH_HI = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                low_carry,
  input  logic                load,
  input  logic [WIDTH_HI-1:0] data_hi,
  input  logic                clr_ovf,
  output logic [WIDTH_HI-1:0] high_count,
  output logic                overflow
);

  // The full count wraps only when the upper half is all-ones and the lower
  // half carries; a load on the same edge replaces the count instead.
  logic wrap;
  assign wrap = (&high_count) && low_carry && !load;

  // Load beats carry; carry increments modulo 2^WIDTH_HI
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      high_count <= '0;
    end else if (load) begin
      high_count <= data_hi;
    end else if (low_carry) begin
      high_count <= high_count + 1'b1;
    end
  end

  // Sticky overflow: a wrap on the same edge as a clear keeps the flag set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (wrap) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/count_cascade_capture.sv
// Extends a 4-bit counter with an upper counter and snapshots {high,low} on request.
// Snapshot appears one edge after Capture_req; High_count lags Low_carry by one edge.
// Snapshot held until Cap_ready; requests arriving while held and not accepted set Cap_miss.
module count_cascade_capture
  import count_cascade_capture_pkg::*;
#(
  parameter int WIDTH_HI = 4
) (
  input  logic                  CLK,
  input  logic                  Clear,
  input  logic [LOW_W-1:0]      Low_count,
  input  logic                  Low_carry,
  input  logic                  Load,
  input  logic [WIDTH_HI-1:0]   Data_hi,
  input  logic                  Clr_ovf,
  input  logic                  Capture_req,
  output logic [WIDTH_HI-1:0]   High_count,
  output logic                  Overflow,
  output logic                  Cap_miss,
  count_cascade_capture_if.master cap
);

  cap_state_t state, state_nxt;
  logic       load_snap;
  logic       drop;
  logic [WIDTH_HI+LOW_W-1:0] snap_q;

  cascade_upper_counter #(
    .WIDTH_HI (WIDTH_HI)
  ) u_upper (
    .clk        (CLK),
    .rst        (Clear),
    .low_carry  (Low_carry),
    .load       (Load),
    .data_hi    (Data_hi),
    .clr_ovf    (Clr_ovf),
    .high_count (High_count),
    .overflow   (Overflow)
  );

  // Capture state register
  always_ff @(posedge CLK or posedge Clear) begin
    if (Clear) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, snapshot load and drop detection; ready is ignored in IDLE
  always_comb begin
    state_nxt = state;
    load_snap = 1'b0;
    drop      = 1'b0;
    case (state)
      IDLE: begin
        if (Capture_req) begin
          load_snap = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (cap.Cap_ready) begin
          if (Capture_req) begin
            load_snap = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else if (Capture_req) begin
          drop = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Snapshot uses pre-edge register values of both halves, so a carry on
  // the capturing edge cannot tear the {high,low} pair.
  always_ff @(posedge CLK or posedge Clear) begin
    if (Clear) begin
      snap_q <= '0;
    end else if (load_snap) begin
      snap_q <= {High_count, Low_count};
    end
  end

  // Sticky miss flag: a drop on the same edge as a clear keeps it set
  always_ff @(posedge CLK or posedge Clear) begin
    if (Clear) begin
      Cap_miss <= 1'b0;
    end else if (drop) begin
      Cap_miss <= 1'b1;
    end else if (Clr_ovf) begin
      Cap_miss <= 1'b0;
    end
  end

  assign cap.Cap_data  = snap_q;
  assign cap.Cap_valid = (state == HOLD);

endmodule

// File: tb/tb_count_cascade_capture.sv
// Directed bench for count_cascade_capture with hand-computed expectations.
// Inputs change 1ns after the rising edge; outputs sampled at that same point.
module tb_count_cascade_capture;

  logic       CLK;
  logic       Clear;
  logic [3:0] Low_count;
  logic       Low_carry;
  logic       Load;
  logic [3:0] Data_hi;
  logic       Clr_ovf;
  logic       Capture_req;
  logic [3:0] High_count;
  logic       Overflow;
  logic       Cap_miss;

  int checks;
  int errors;

  count_cascade_capture_if #(.WIDTH_HI(4)) cap_bus ();

  count_cascade_capture #(
    .WIDTH_HI (4)
  ) dut (
    .CLK         (CLK),
    .Clear       (Clear),
    .Low_count   (Low_count),
    .Low_carry   (Low_carry),
    .Load        (Load),
    .Data_hi     (Data_hi),
    .Clr_ovf     (Clr_ovf),
    .Capture_req (Capture_req),
    .High_count  (High_count),
    .Overflow    (Overflow),
    .Cap_miss    (Cap_miss),
    .cap         (cap_bus.master)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs set before the call are sampled on it
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    Clear       = 1'b1;
    Low_count   = 4'h0;
    Low_carry   = 1'b0;
    Load        = 1'b0;
    Data_hi     = 4'h0;
    Clr_ovf     = 1'b0;
    Capture_req = 1'b0;
    cap_bus.Cap_ready = 1'b0;

    #3;
    chk("rst_high", High_count, 4'h0);
    chk("rst_ovf", Overflow, 1'b0);
    chk("rst_data", cap_bus.Cap_data, 8'h00);
    chk("rst_valid", cap_bus.Cap_valid, 1'b0);
    chk("rst_miss", Cap_miss, 1'b0);
    step();
    Clear = 1'b0;

    // Load E, then two carries 16 cycles apart: E -> F -> 0 with overflow
    Load = 1'b1; Data_hi = 4'hE;
    step();
    Load = 1'b0;
    chk("load_E", High_count, 4'hE);
    Low_carry = 1'b1;
    step();
    Low_carry = 1'b0;
    chk("inc_F", High_count, 4'hF);
    chk("ovf_not_yet", Overflow, 1'b0);
    repeat (15) step();
    chk("hold_F", High_count, 4'hF);
    Low_carry = 1'b1;
    step();
    Low_carry = 1'b0;
    chk("wrap_0", High_count, 4'h0);
    chk("ovf_set", Overflow, 1'b1);
    Clr_ovf = 1'b1;
    step();
    Clr_ovf = 1'b0;
    chk("ovf_clr", Overflow, 1'b0);

    // Wrap and clear on the same edge: the set wins
    Load = 1'b1; Data_hi = 4'hF;
    step();
    Load = 1'b0;
    Low_carry = 1'b1; Clr_ovf = 1'b1;
    step();
    Low_carry = 1'b0; Clr_ovf = 1'b0;
    chk("ovf_set_wins", Overflow, 1'b1);
    chk("wrap_again", High_count, 4'h0);

    // Load and carry together: load wins, overflow untouched (still 1)
    Load = 1'b1; Low_carry = 1'b1; Data_hi = 4'h7;
    step();
    Load = 1'b0; Low_carry = 1'b0;
    chk("load_beats_carry", High_count, 4'h7);
    chk("ovf_kept_by_load", Overflow, 1'b1);
    Clr_ovf = 1'b1;
    step();
    Clr_ovf = 1'b0;

    // Coherent snapshot on a carry edge: pre-edge {3,F}
    Load = 1'b1; Data_hi = 4'h3;
    step();
    Load = 1'b0;
    Low_count = 4'hF; Low_carry = 1'b1; Capture_req = 1'b1;
    step();
    Low_carry = 1'b0; Capture_req = 1'b0; Low_count = 4'h0;
    chk("snap_3F", cap_bus.Cap_data, 8'h3F);
    chk("snap_valid", cap_bus.Cap_valid, 1'b1);
    chk("high_after_carry", High_count, 4'h4);

    // Request while held and not accepted: dropped
    Low_count = 4'hA; Capture_req = 1'b1;
    step();
    Capture_req = 1'b0;
    chk("drop_data_held", cap_bus.Cap_data, 8'h3F);
    chk("drop_miss", Cap_miss, 1'b1);
    chk("drop_valid_held", cap_bus.Cap_valid, 1'b1);
    cap_bus.Cap_ready = 1'b1;
    step();
    chk("accept_valid_low", cap_bus.Cap_valid, 1'b0);
    // Ready while idle does nothing
    step();
    cap_bus.Cap_ready = 1'b0;
    chk("idle_ready_ignored", cap_bus.Cap_valid, 1'b0);
    chk("miss_sticky", Cap_miss, 1'b1);
    Clr_ovf = 1'b1;
    step();
    Clr_ovf = 1'b0;
    chk("miss_clr", Cap_miss, 1'b0);

    // Back-to-back accept and new capture: no bubble
    Load = 1'b1; Data_hi = 4'h5;
    step();
    Load = 1'b0;
    Low_count = 4'h1; Capture_req = 1'b1;
    step();
    chk("snap_51", cap_bus.Cap_data, 8'h51);
    Low_count = 4'h2; cap_bus.Cap_ready = 1'b1;
    step();
    Capture_req = 1'b0; cap_bus.Cap_ready = 1'b0;
    chk("b2b_data_52", cap_bus.Cap_data, 8'h52);
    chk("b2b_valid", cap_bus.Cap_valid, 1'b1);
    chk("b2b_no_miss", Cap_miss, 1'b0);

    // Drop coinciding with Clr_ovf: drop wins
    Capture_req = 1'b1; Clr_ovf = 1'b1; Low_count = 4'h9;
    step();
    Capture_req = 1'b0; Clr_ovf = 1'b0;
    chk("drop_wins_clr", Cap_miss, 1'b1);
    chk("drop_wins_data", cap_bus.Cap_data, 8'h52);

    // Asynchronous clear mid-handshake, observed before the next edge
    #3;
    Clear = 1'b1;
    #1;
    chk("aclr_high", High_count, 4'h0);
    chk("aclr_ovf", Overflow, 1'b0);
    chk("aclr_data", cap_bus.Cap_data, 8'h00);
    chk("aclr_valid", cap_bus.Cap_valid, 1'b0);
    chk("aclr_miss", Cap_miss, 1'b0);
    step();
    Clear = 1'b0;
    // FSM left in IDLE: a held ready does not matter, a request captures
    cap_bus.Cap_ready = 1'b1;
    step();
    chk("post_clr_idle", cap_bus.Cap_valid, 1'b0);
    cap_bus.Cap_ready = 1'b0;
    Low_count = 4'h6; Capture_req = 1'b1;
    step();
    Capture_req = 1'b0;
    chk("post_clr_snap", cap_bus.Cap_data, 8'h06);
    chk("post_clr_valid", cap_bus.Cap_valid, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
